// File: rtl/alu_issue_if.sv
// alu_issue_if: upstream/downstream handshake and decoded-operand bus of the ALU issue stage
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  rd;
  logic        wr_en;
  logic        illegal;
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, op, data1, data2, rd, wr_en, illegal
  );
  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, op, data1, data2, rd, wr_en, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I OP/OP-IMM decode into a one-entry issue register; UPPER_DECODE_EN adds LUI/AUIPC
module alu_issue_stage (
  input logic       clk,
  input logic       rst,
  alu_issue_if.slave s
);
  localparam logic [7:0] OP_MAP [8] = '{8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10};
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        shift;
  logic        acc;
  logic [7:0]  dop;
  logic [31:0] d1;
  logic [31:0] d2;
  assign opc = s.instr[6:0];
  assign f7 = s.instr[31:25];
  assign f3 = s.instr[14:12];
  assign shift = f3[1:0] == 2'b01;
  assign s.in_ready = !s.out_valid || s.out_ready;
  assign acc = s.in_valid && s.in_ready;
  always_comb begin
    dop = 8'd0;
    d1 = s.rs1_data;
    d2 = s.rs2_data;
    case (opc)
      7'b0110011: begin
        dop = f7 == 7'h00 ? OP_MAP[f3] :
              (f7 == 7'h20 && f3 == 3'd0) ? 8'd2 :
              (f7 == 7'h20 && f3 == 3'd5) ? 8'd8 : 8'd0;
        d2 = shift ? {27'b0, s.rs2_data[4:0]} : s.rs2_data;
      end
      7'b0010011: begin
        dop = (!shift || f7 == 7'h00) ? OP_MAP[f3] :
              (f7 == 7'h20 && f3 == 3'd5) ? 8'd8 : 8'd0;
        d2 = shift ? {27'b0, s.instr[24:20]} : {{20{s.instr[31]}}, s.instr[31:20]};
      end
`ifdef UPPER_DECODE_EN
      7'b0110111: begin
        dop = 8'd1;
        d1 = 32'd0;
        d2 = {s.instr[31:12], 12'b0};
      end
      7'b0010111: begin
        dop = 8'd1;
        d1 = s.pc;
        d2 = {s.instr[31:12], 12'b0};
      end
`endif
      default: dop = 8'd0;
    endcase
    // undecodable instructions carry zero operands
    if (dop == 8'd0) begin
      d1 = 32'd0;
      d2 = 32'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s.out_valid <= 1'b0;
      s.op <= 8'd0;
      s.data1 <= 32'd0;
      s.data2 <= 32'd0;
      s.rd <= 5'd0;
      s.wr_en <= 1'b0;
      s.illegal <= 1'b0;
    end else if (s.flush) begin
      s.out_valid <= 1'b0;
    end else if (acc) begin
      s.out_valid <= 1'b1;
      s.op <= dop;
      s.data1 <= d1;
      s.data2 <= d2;
      s.rd <= s.instr[11:7];
      s.wr_en <= dop != 8'd0 && s.instr[11:7] != 5'd0;
      s.illegal <= dop == 8'd0;
    end else if (s.out_ready) begin
      s.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized scoreboard bench for alu_issue_stage; honours UPPER_DECODE_EN
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  alu_issue_if bus();
  alu_issue_stage dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;
  exp_t q[$];
  bit started = 0;
  bit was_rst = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = '0;
    e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        e.d1 = a;
        e.d2 = b;
        case ({ins[31:25], ins[14:12]})
          {7'h00, 3'd0}: e.op = 1;
          {7'h20, 3'd0}: e.op = 2;
          {7'h00, 3'd1}: begin e.op = 3; e.d2 = b % 32; end
          {7'h00, 3'd2}: e.op = 4;
          {7'h00, 3'd3}: e.op = 5;
          {7'h00, 3'd4}: e.op = 6;
          {7'h00, 3'd5}: begin e.op = 7; e.d2 = b % 32; end
          {7'h20, 3'd5}: begin e.op = 8; e.d2 = b % 32; end
          {7'h00, 3'd6}: e.op = 9;
          {7'h00, 3'd7}: e.op = 10;
          default: ;
        endcase
      end
      7'h13: begin
        e.d1 = a;
        e.d2 = 32'($signed(ins[31:20]));
        case (ins[14:12])
          3'd0: e.op = 1;
          3'd2: e.op = 4;
          3'd3: e.op = 5;
          3'd4: e.op = 6;
          3'd6: e.op = 9;
          3'd7: e.op = 10;
          3'd1: if (ins[31:25] == 7'h00) begin e.op = 3; e.d2 = 32'(ins[24:20]); end
          default: begin
            if (ins[31:25] == 7'h00) begin e.op = 7; e.d2 = 32'(ins[24:20]); end
            else if (ins[31:25] == 7'h20) begin e.op = 8; e.d2 = 32'(ins[24:20]); end
          end
        endcase
      end
`ifdef UPPER_DECODE_EN
      7'h37: begin e.op = 1; e.d1 = 0; e.d2 = ins & 32'hFFFFF000; end
      7'h17: begin e.op = 1; e.d1 = p; e.d2 = ins & 32'hFFFFF000; end
`endif
      default: ;
    endcase
    e.ill = e.op == 0;
    if (e.ill) begin
      e.d1 = 0;
      e.d2 = 0;
    end
    e.we = !e.ill && e.rd != 0;
    return e;
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0, 1: w[6:0] = 7'h33;
      2, 3: w[6:0] = 7'h13;
      4: w[6:0] = $urandom_range(0, 1) != 0 ? 7'h37 : 7'h17;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) != 0 ? 7'h00 : 7'h20;
    return w;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    bit acc;
    if (started) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() == 0 || bus.out_ready));
      if (q.size() != 0 || was_rst) begin
        e = q.size() != 0 ? q[0] : '0;
        chk("op", 32'(bus.op), 32'(e.op));
        chk("data1", bus.data1, e.d1);
        chk("data2", bus.data2, e.d2);
        chk("rd", 32'(bus.rd), 32'(e.rd));
        chk("wr_en", 32'(bus.wr_en), 32'(e.we));
        chk("illegal", 32'(bus.illegal), 32'(e.ill));
      end
    end
    was_rst = rst;
    if (rst) begin
      q.delete();
      started = 1;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      acc = bus.in_valid && (q.size() == 0 || bus.out_ready);
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (acc) q.push_back(model(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data));
    end
  end
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, input logic fl, input logic r);
    bus.in_valid = iv;
    bus.instr = ins;
    bus.pc = p;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.out_ready = ordy;
    bus.flush = fl;
    rst = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 32'h00500093, 32'h100, 0, 0, 1, 0, 0);
    step(1, 32'h40315213, 32'h104, 32'h80000000, 0, 1, 0, 0);
    step(1, 32'h007312B3, 32'h108, 32'h1234, 32'hFFFFFF21, 1, 0, 0);
    step(1, 32'h00a00113, 32'h10c, 32'h0, 32'h0, 1, 0, 0);
    repeat (3) step(1, 32'h00100193, 32'h110, 32'h7, 32'h9, 0, 0, 0);
    step(1, 32'h00100193, 32'h110, 32'h7, 32'h9, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 32'h0000007F, 32'h114, 32'h55, 32'h66, 1, 0, 0);
    step(1, 32'h400010B3, 32'h118, 32'h55, 32'h66, 1, 0, 0);
    step(1, 32'h00500013, 32'h11c, 32'h55, 32'h66, 1, 0, 0);
    step(1, 32'h00700213, 32'h120, 32'h1, 32'h2, 1, 0, 0);
    step(1, 32'h00800293, 32'h124, 32'h1, 32'h2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 32'h00900313, 32'h128, 32'h3, 32'h4, 1, 0, 0);
    step(1, 32'h00a00393, 32'h12c, 32'h3, 32'h4, 0, 0, 0);
    step(1, 32'h00b00413, 32'h130, 32'h3, 32'h4, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 32'h123450B7, 32'h134, 32'hAAAA, 32'hBBBB, 1, 0, 0);
    step(1, 32'h12345097, 32'h1000, 32'hAAAA, 32'hBBBB, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3000)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 in_valid  input  1  upstream presents an instruction.
REQ-004 in_ready  output  1  stage accepts an instruction this cycle.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 pc  input  32  address of instr.
REQ-007 rs1_data  input  32  register-file value of instr[19:15].
REQ-008 rs2_data  input  32  register-file value of instr[24:20].
REQ-009 flush  input  1  discard held and incoming instruction.
REQ-010 out_valid  output  1  issue register holds an instruction.
REQ-011 out_ready  input  1  downstream consumes the held instruction.
REQ-012 op  output  8  ALU opcode: 1 add, 2 sub, 3 sll, 4 slt, 5 sltu, 6 xor, 7 srl, 8 sra, 9 or, a and, 0 nop.
REQ-013 data1  output  32  ALU first operand.
REQ-014 data2  output  32  ALU second operand.
REQ-015 rd  output  5  destination register.
REQ-016 wr_en  output  1  writeback enable.
REQ-017 illegal  output  1  held instruction not decodable.

Function
REQ-018 Accept (in_valid && in_ready) SHALL load decoded fields into the issue register; latency exactly 1 cycle to out_valid.
REQ-019 in_ready SHALL equal !out_valid || out_ready (combinational; simultaneous consume and accept passes back-to-back at 1 instr/cycle).
REQ-020 out_valid SHALL clear after a consume with no accept; outputs SHALL hold stable while out_valid && !out_ready.
REQ-021 OP (opcode 0110011): funct7 0000000 maps funct3 000..111 to add, sll, slt, sltu, xor, srl, or, and; funct7 0100000 with funct3 000 -> sub, 101 -> sra; data1 = rs1_data, data2 = rs2_data except shifts.
REQ-022 OP-IMM (0010011): addi, slti, sltiu, xori, ori, andi with data2 = sign-extended instr[31:20]; slli requires funct7 0000000, srli 0000000, srai 0100000.
REQ-023 All shifts SHALL drive data2 = {27'b0, shamt}, shamt = instr[24:20] (imm) or rs2_data[4:0] (reg), since the ALU shifts by full data2.
REQ-024 Any other opcode/funct7/funct3 combination SHALL register illegal = 1, op = 0, wr_en = 0, data1 = data2 = 0.
REQ-025 wr_en SHALL be 1 for legal instructions with rd != 0, else 0; rd = instr[11:7] always.
REQ-026 flush SHALL clear out_valid next cycle and suppress any same-cycle accept; flush has priority over accept and consume.
REQ-027 Registered fields SHALL update only on accept; out_valid = 0 SHALL not require fields to be zero except after reset.

Reset
REQ-028 rst SHALL force out_valid = 0, op = 0, data1 = 0, data2 = 0, rd = 0, wr_en = 0, illegal = 0 on the next edge, overriding accept and flush; reset mid-stall drops the held instruction.
REQ-029 in_ready SHALL be 1 in the cycle after reset.

Configuration
REQ-030 With UPPER_DECODE_EN defined: LUI (0110111) -> op 1, data1 = 0, data2 = {instr[31:12], 12'b0}; AUIPC (0010111) -> op 1, data1 = pc, same data2.
REQ-031 Without UPPER_DECODE_EN: LUI and AUIPC SHALL decode as illegal per REQ-024.

Verification
REQ-032 Reset, then instr 0x00500093 (addi x1,x0,5), rs1_data 0 -> next cycle out_valid 1, op 1, data2 0x5, rd 1, wr_en 1.
REQ-033 instr 0x40315213 (srai x4,x2,3), rs1_data 0x80000000 -> op 8, data1 0x80000000, data2 0x3; sll reg with rs2_data 0xFFFFFF21 -> data2 0x1.
REQ-034 out_ready 0 for 3 cycles with in_valid 1 -> in_ready 0, outputs unchanged; out_ready 1 -> consume and accept same cycle, next instruction appears next cycle.
REQ-035 instr 0x0000007F and sub with funct3 001 -> illegal 1, op 0, wr_en 0; addi with rd 0 -> wr_en 0, illegal 0.
REQ-036 flush with in_valid 1 and held instruction -> out_valid 0 next cycle; rst asserted during stall -> all outputs 0 next cycle.
REQ-037 LUI 0x123450B7 -> with UPPER_DECODE_EN op 1, data2 0x12345000; without it illegal 1.
